// File: rtl/ps2_host_tx_pkg.sv
// Shared state encoding and timing derivations for the PS/2 host transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        BITS,
        WAITIDLE,
        DONE,
        ERROR
    } ps2tx_state_t;

    // 120 us clock inhibit before request-to-send
    function automatic int t_inh_cycles(input int clk_freq);
        return (clk_freq / 1_000_000) * 120;
    endfunction

    function automatic int t_rts_cycles(input int clk_freq);
        return clk_freq / 1_000_000;
    endfunction

    // 15 ms for the device to start clocking after release
    function automatic int t_start_cycles(input int clk_freq);
        return clk_freq * 15 / 1000;
    endfunction

    function automatic int t_pkt_cycles(input int clk_freq);
        return clk_freq * 2 / 1000;
    endfunction

    function automatic int timer_width(input int clk_freq);
        return $clog2(clk_freq * 15 / 1000 + 1);
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the requester and the PS/2 host transmitter.
// tx_data is taken in the cycle where tx_valid && tx_ready; tx_valid while tx_ready is low is dropped, not queued.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_error, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_error, busy
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one open-drain PS/2 line.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level
);
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(FILTER_LEN - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // Idle bus is high, so everything resets to 1 to avoid a spurious fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == L_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 28_000_000,
    parameter int FILTER_LEN = 8
) (
    input  logic         clk28,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe,
    output ps2tx_state_t dbg_state
);
    localparam int TMR_W = timer_width(CLK_FREQ);
    localparam logic [TMR_W-1:0] L_INH   = TMR_W'(t_inh_cycles(CLK_FREQ) - 1);
    localparam logic [TMR_W-1:0] L_RTS   = TMR_W'(t_rts_cycles(CLK_FREQ) - 1);
    localparam logic [TMR_W-1:0] L_START = TMR_W'(t_start_cycles(CLK_FREQ) - 1);
    localparam logic [TMR_W-1:0] L_PKT   = TMR_W'(t_pkt_cycles(CLK_FREQ) - 1);

    logic             w_clk_lvl, w_dat_lvl, w_clk_fall, w_tmr_zero;
    logic             r_clk_prev;
    ps2tx_state_t     r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [3:0]       r_bitn, w_bitn_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_par, w_par_nxt;
    logic             r_dat_oe, w_dat_oe_nxt;
    logic             r_clk_oe, r_busy, r_ready, r_done, r_error;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk28), .rst(rst), .i_pin(ps2_clk_in), .o_level(w_clk_lvl)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk(clk28), .rst(rst), .i_pin(ps2_dat_in), .o_level(w_dat_lvl)
    );

    assign w_clk_fall = r_clk_prev & ~w_clk_lvl;
    assign w_tmr_zero = (r_timer == '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_bitn_nxt   = r_bitn;
        w_data_nxt   = r_data;
        w_par_nxt    = r_par;
        w_dat_oe_nxt = r_dat_oe;
        case (r_state)
            IDLE: begin
                if (tx.tx_valid && r_ready) begin
                    w_state_nxt = INHIBIT;
                    w_timer_nxt = L_INH;
                    w_data_nxt  = tx.tx_data;
                    w_par_nxt   = ~^tx.tx_data;
                end
            end
            INHIBIT: begin
                if (w_tmr_zero) begin
                    w_state_nxt  = RTS;
                    w_timer_nxt  = L_RTS;
                    w_dat_oe_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            RTS: begin
                if (w_tmr_zero) begin
                    w_state_nxt = BITS;
                    w_timer_nxt = L_START;
                    w_bitn_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            BITS: begin
                if (w_clk_fall) begin
                    w_bitn_nxt = r_bitn + 4'd1;
                    // First device clock swaps the start timeout for the whole-packet timeout.
                    if (r_bitn == 4'd0) begin
                        w_timer_nxt = L_PKT;
                    end else if (!w_tmr_zero) begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                    if (r_bitn < 4'd8) begin
                        w_dat_oe_nxt = ~r_data[r_bitn[2:0]];
                    end else if (r_bitn == 4'd8) begin
                        w_dat_oe_nxt = ~r_par;
                    end else if (r_bitn == 4'd9) begin
                        w_dat_oe_nxt = 1'b0;
                    end else begin
                        w_state_nxt = w_dat_lvl ? ERROR : WAITIDLE;
                    end
                end else if (w_tmr_zero) begin
                    w_state_nxt = ERROR;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            WAITIDLE: begin
                if (w_clk_lvl && w_dat_lvl) begin
                    w_state_nxt = DONE;
                end else if (w_tmr_zero) begin
                    w_state_nxt = ERROR;
                end else begin
                    w_timer_nxt = r_timer - TMR_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            ERROR:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (!(w_state_nxt inside {RTS, BITS, WAITIDLE})) begin
            w_dat_oe_nxt = 1'b0;
        end
    end

    // Outputs are registered from the next state so the pin enables never glitch.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_bitn     <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_clk_prev <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_bitn     <= w_bitn_nxt;
            r_data     <= w_data_nxt;
            r_par      <= w_par_nxt;
            r_dat_oe   <= w_dat_oe_nxt;
            r_clk_oe   <= (w_state_nxt == INHIBIT) || (w_state_nxt == RTS);
            r_busy     <= w_state_nxt inside {INHIBIT, RTS, BITS, WAITIDLE};
            r_ready    <= (w_state_nxt == IDLE);
            r_done     <= (w_state_nxt == DONE);
            r_error    <= (w_state_nxt == ERROR);
            r_clk_prev <= w_clk_lvl;
        end
    end

    assign tx.tx_ready = r_ready;
    assign tx.tx_done  = r_done;
    assign tx.tx_error = r_error;
    assign tx.busy     = r_busy;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_dat_oe  = r_dat_oe;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model and a per-fall data scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  // 2 MHz system clock keeps the 15 ms timeout short in cycles.
  localparam int CLK_FREQ   = 2_000_000;
  localparam int FILTER_LEN = 8;
  localparam int T_INH      = 240;
  localparam int T_RTS      = 2;
  localparam int T_START    = 30000;
  localparam int T_PKT      = 4000;
  localparam int LAT        = 2 + FILTER_LEN + 1;
  localparam int DEV_HALF   = 80;

  // clock / reset
  logic clk28 = 1'b0;
  logic rst;
  always #250 clk28 = ~clk28;

  logic         ps2_clk_oe, ps2_dat_oe;
  logic         ps2_clk_in, ps2_dat_in;
  logic         dev_clk_low, dev_dat_low;
  ps2tx_state_t dbg_state;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(.CLK_FREQ(CLK_FREQ), .FILTER_LEN(FILTER_LEN)) dut (
    .clk28      (clk28),
    .rst        (rst),
    .tx         (tx_if),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .dbg_state  (dbg_state)
  );

  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  always @(posedge clk28) begin
    cyc <= cyc + 1;
    if (tx_if.tx_done) n_done <= n_done + 1;
    if (tx_if.tx_error) n_err <= n_err + 1;
    if (tx_if.tx_done && tx_if.tx_error) n_both <= n_both + 1;
  end

  // scoreboard
  logic [0:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int t_rel = 0;
  int t_fall0 = 0;
  int t_res = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // driver tasks
  task automatic send(input logic [7:0] d, input bit push, input bit chk_timing, input bit poke);
    int c;
    c = 0;
    while (!tx_if.tx_ready && c < 1000) begin
      @(negedge clk28);
      c++;
    end
    chk("ready_before_send", 32'(tx_if.tx_ready), 32'd1);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk28);
    tx_if.tx_valid = 1'b0;
    if (push) begin
      for (int b = 0; b < 8; b++) exp_q.push_back(~d[b]);
      exp_q.push_back(~(~^d));
      exp_q.push_back(1'b0);
    end
    if (chk_timing) begin
      chk("accept_busy", 32'(tx_if.busy), 32'd1);
      chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
      chk("accept_ready", 32'(tx_if.tx_ready), 32'd0);
      c = 0;
      while (ps2_clk_oe && !ps2_dat_oe && c < T_INH + 100) begin
        c++;
        @(negedge clk28);
      end
      chk("inhibit_len", 32'(c), 32'(T_INH));
      c = 0;
      while (ps2_clk_oe && ps2_dat_oe && c < 100) begin
        c++;
        @(negedge clk28);
      end
      chk("rts_len", 32'(c), 32'(T_RTS));
      chk("start_bit_held", 32'(ps2_dat_oe), 32'd1);
    end else begin
      if (poke) begin
        tx_if.tx_data  = 8'hAA;
        tx_if.tx_valid = 1'b1;
        repeat (5) @(negedge clk28);
        tx_if.tx_valid = 1'b0;
      end
      c = 0;
      while (ps2_clk_oe && c < T_INH + T_RTS + 100) begin
        c++;
        @(negedge clk28);
      end
      chk("release_wait", 32'(ps2_clk_oe), 32'd0);
    end
    t_rel = cyc;
  endtask

  task automatic dev_frame(input int nclk, input bit ack, input int rst_at, input bit glitch);
    logic [0:0] exp_v;
    for (int i = 0; i < nclk; i++) begin
      if (i == 10 && ack) dev_dat_low = 1'b1;
      if (glitch && i == 3) begin
        repeat (30) @(negedge clk28);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk28);
        dev_clk_low = 1'b0;
        repeat (DEV_HALF - 33) @(negedge clk28);
      end else begin
        repeat (DEV_HALF) @(negedge clk28);
      end
      dev_clk_low = 1'b1;
      if (i == 0) t_fall0 = cyc;
      if (i == 10 && !ack) return;
      repeat (5) @(negedge clk28);
      if (i == rst_at) begin
        #100 rst = 1'b1;
        #1;
        chk("rst_mid_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_mid_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("rst_mid_ready", 32'(tx_if.tx_ready), 32'd1);
        chk("rst_mid_busy", 32'(tx_if.busy), 32'd0);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge clk28);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      repeat (15) @(negedge clk28);
      if (i < 10) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("stream_underflow_fall%0d", i), 32'd1, 32'd0);
        end else begin
          exp_v = exp_q.pop_front();
          chk($sformatf("dat_oe_fall%0d", i), 32'(ps2_dat_oe), 32'(exp_v));
        end
      end
      repeat (DEV_HALF - 20) @(negedge clk28);
      dev_clk_low = 1'b0;
    end
    repeat (DEV_HALF / 2) @(negedge clk28);
    dev_dat_low = 1'b0;
  endtask

  task automatic finish_check(input bit exp_done, input string tag, output int t_out);
    int c;
    c = 0;
    while (!tx_if.tx_done && !tx_if.tx_error && c < T_START + 1000) begin
      @(negedge clk28);
      c++;
    end
    t_out = cyc;
    chk({tag, "_done"}, 32'(tx_if.tx_done), 32'(exp_done));
    chk({tag, "_error"}, 32'(tx_if.tx_error), 32'(!exp_done));
    chk({tag, "_busy"}, 32'(tx_if.busy), 32'd0);
    chk({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
    chk({tag, "_dat_oe"}, 32'(ps2_dat_oe), 32'd0);
    @(negedge clk28);
    chk({tag, "_ready_after"}, 32'(tx_if.tx_ready), 32'd1);
    chk({tag, "_pulse_end"}, 32'(tx_if.tx_done | tx_if.tx_error), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'h00;
    repeat (5) @(negedge clk28);
    chk("rst_ready", 32'(tx_if.tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_if.busy), 32'd0);
    chk("rst_done", 32'(tx_if.tx_done), 32'd0);
    chk("rst_error", 32'(tx_if.tx_error), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    repeat (20) @(negedge clk28);

    send(8'hED, 1'b1, 1'b1, 1'b0);
    dev_frame(11, 1'b1, -1, 1'b0);
    finish_check(1'b1, "ed", t_res);
    chk("ed_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (50) @(negedge clk28);

    send(8'h01, 1'b1, 1'b0, 1'b1);
    dev_frame(11, 1'b1, -1, 1'b0);
    finish_check(1'b1, "x01", t_res);
    repeat (50) @(negedge clk28);

    send(8'hFF, 1'b1, 1'b0, 1'b0);
    dev_frame(11, 1'b1, -1, 1'b0);
    finish_check(1'b1, "xff", t_res);
    repeat (50) @(negedge clk28);

    send(8'h00, 1'b0, 1'b0, 1'b0);
    finish_check(1'b0, "noclk", t_res);
    chk("noclk_time", 32'(t_res - t_rel), 32'(T_START));
    repeat (50) @(negedge clk28);

    send(8'h3C, 1'b1, 1'b0, 1'b0);
    dev_frame(5, 1'b1, -1, 1'b0);
    finish_check(1'b0, "pkt", t_res);
    chk("pkt_time", 32'(t_res - t_fall0), 32'(T_PKT + LAT));
    exp_q.delete();
    repeat (50) @(negedge clk28);

    send(8'h5A, 1'b1, 1'b0, 1'b0);
    dev_frame(11, 1'b0, -1, 1'b0);
    finish_check(1'b0, "noack", t_res);
    dev_clk_low = 1'b0;
    chk("noack_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (50) @(negedge clk28);

    send(8'h55, 1'b1, 1'b0, 1'b0);
    dev_frame(11, 1'b1, 4, 1'b0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    repeat (50) @(negedge clk28);

    send(8'hF4, 1'b1, 1'b0, 1'b0);
    dev_frame(11, 1'b1, -1, 1'b1);
    finish_check(1'b1, "f4", t_res);
    chk("f4_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk28);

    chk("total_done", 32'(n_done), 32'd4);
    chk("total_error", 32'(n_err), 32'd3);
    chk("done_and_error", 32'(n_both), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
